// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   fwd_t       - EX operand select encodings (ID/EX bus, EX/MEM result, MEM/WB value)
//   state_t     - control FSM states
//   sb_entry_t  - one scoreboard slot shadowing an instruction in EX, MEM or WB
//   NOP         - instruction word loaded into IF/ID on a squash
//   writes_reg  - true when a scoreboard slot will write a given non-zero register
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       reg_wr;
    logic       load;
    logic       branch;
    logic [4:0] rw;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } sb_entry_t;

  localparam logic [31:0] NOP = 32'h0;

  // Register 0 is hardwired to zero, so it is never a hazard or a forward source.
  function automatic logic writes_reg(input sb_entry_t e, input logic [4:0] r);
    return e.valid & e.reg_wr & (e.rw == r) & (r != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: operand-forwarding select for one EX-stage ALU input.
//   src    - source register read by the instruction in EX
//   uses   - the EX instruction actually reads src
//   mem_e  - scoreboard slot for the instruction in MEM
//   wb_e   - scoreboard slot for the instruction in WB
//   sel    - FWD_MEM if MEM produces src, else FWD_WB if WB does, else FWD_REG
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       uses,
  input  sb_entry_t  mem_e,
  input  sb_entry_t  wb_e,
  output logic [1:0] sel
);

  // A load sitting in MEM with a consumer in EX cannot occur: the load-use
  // stall always separates them by one slot, so no load check is needed here.
  always_comb begin
    sel = FWD_REG;
    if (uses && writes_reg(mem_e, src)) begin
      sel = FWD_MEM;
    end else if (uses && writes_reg(wb_e, src)) begin
      sel = FWD_WB;
    end
  end

  // Slot fields that carry no forwarding information for this operand.
  logic unused_fields;
  assign unused_fields = ^{mem_e.load, mem_e.branch, mem_e.rs, mem_e.rt,
                           mem_e.uses_rs, mem_e.uses_rt,
                           wb_e.load, wb_e.branch, wb_e.rs, wb_e.rt,
                           wb_e.uses_rs, wb_e.uses_rt};

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the five-stage CPU.
// Keeps a shadow scoreboard of EX/MEM/WB, produces forwarding selects, a
// one-cycle load-use stall and a two-slot squash on a taken branch.
//   clk, reset            - CPU clock (state moves on the falling edge), async active-high reset
//   id_rs, id_rt          - ID source registers; id_uses_rs/id_uses_rt say whether they are read
//   id_rw, id_reg_wr      - ID destination register and its write enable
//   id_load, id_branch    - ID instruction is lw / a conditional branch
//   ex_taken              - branch outcome from EX
//   fwd_a, fwd_b          - EX operand selects (see hazard_pkg::fwd_t)
//   pc_hold, ifid_hold    - freeze PC and IF/ID
//   ifid_flush            - load NOP into IF/ID
//   idex_bubble           - load all-zero control into ID/EX
//   stall_cnt, flush_cnt  - saturating counts of stall and flush cycles
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_rw,
  input  logic             id_reg_wr,
  input  logic             id_load,
  input  logic             id_branch,
  input  logic             ex_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t    state, next_state;
  sb_entry_t ex_e, mem_e, wb_e;
  sb_entry_t id_e;

  logic load_use;
  logic br_taken;

  always_comb begin
    id_e         = '0;
    id_e.valid   = 1'b1;
    id_e.reg_wr  = id_reg_wr;
    id_e.load    = id_load;
    id_e.branch  = id_branch;
    id_e.rw      = id_rw;
    id_e.rs      = id_rs;
    id_e.rt      = id_rt;
    id_e.uses_rs = id_uses_rs;
    id_e.uses_rt = id_uses_rt;
  end

  assign load_use = ex_e.load &
                    ((id_uses_rs & writes_reg(ex_e, id_rs)) |
                     (id_uses_rt & writes_reg(ex_e, id_rt)));
  assign br_taken = ex_taken & ex_e.valid & ex_e.branch;

  // A taken branch wins over a load-use stall: the stalled instruction is on
  // the wrong path and gets squashed anyway.
  always_comb begin
    next_state  = ST_RUN;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (load_use) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            next_state  = ST_STALL;
          end
        end
        ST_STALL: next_state = ST_RUN;
        default:  next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      ex_e  <= '0;
      mem_e <= '0;
      wb_e  <= '0;
    end else begin
      wb_e  <= mem_e;
      mem_e <= ex_e;
      ex_e  <= idex_bubble ? sb_entry_t'('0) : id_e;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_hold && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  fwd_sel u_fwd_a (
    .src   (ex_e.rs),
    .uses  (ex_e.uses_rs),
    .mem_e (mem_e),
    .wb_e  (wb_e),
    .sel   (fwd_a)
  );

  fwd_sel u_fwd_b (
    .src   (ex_e.rt),
    .uses  (ex_e.uses_rt),
    .mem_e (mem_e),
    .wb_e  (wb_e),
    .sel   (fwd_b)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against an
// instruction-level pipeline model.
module tb_hazard_ctrl;

  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b1;
  logic          reset = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, id_rw = '0;
  logic          id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic          id_reg_wr = 1'b0, id_load = 1'b0, id_branch = 1'b0;
  logic          ex_taken = 1'b0;
  logic [1:0]    fwd_a, fwd_b;
  logic          pc_hold, ifid_hold, ifid_flush, idex_bubble;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_rw       (id_rw),
    .id_reg_wr   (id_reg_wr),
    .id_load     (id_load),
    .id_branch   (id_branch),
    .ex_taken    (ex_taken),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .pc_hold     (pc_hold),
    .ifid_hold   (ifid_hold),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid, wr, load, br, urs, urt;
    int rw, rs, rt;
  } ins_t;

  int   tests = 0;
  int   failed = 0;
  ins_t ex_m, mem_m, wb_m, empty;
  int   m_sc, m_fc;
  bit   last_stall;
  int   obs_fa, obs_fb, obs_hold, obs_flush, obs_bub;

  function automatic ins_t mk(bit wr, bit ld, bit br, int rw, int rs, int rt, bit urs, bit urt);
    ins_t i;
    i.valid = 1'b1; i.wr = wr; i.load = ld; i.br = br;
    i.rw = rw; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    return i;
  endfunction

  function automatic bit writer(ins_t e, int r);
    return e.valid && e.wr && e.rw == r && r != 0;
  endfunction

  // Nearest older producer wins: MEM before WB.
  function automatic int fsel(bit u, int r);
    if (u && writer(mem_m, r)) return 1;
    if (u && writer(wb_m, r)) return 2;
    return 0;
  endfunction

  function automatic ins_t rnd();
    int k = $urandom_range(0, 3);
    int a = $urandom_range(0, 3), b = $urandom_range(0, 3), d = $urandom_range(0, 3);
    case (k)
      0: return mk(1, 0, 0, d, a, b, 1, 1);
      1: return mk(1, 1, 0, d, a, 0, 1, 0);
      2: return mk(0, 0, 1, 0, a, b, 1, 1);
      default: return mk(0, 0, 0, 0, a, b, 1, 1);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    ex_m = empty; mem_m = empty; wb_m = empty;
    m_sc = 0; m_fc = 0; last_stall = 0;
  endtask

  task automatic drive(input ins_t id, input bit tk);
    id_rs = 5'(id.rs); id_rt = 5'(id.rt); id_rw = 5'(id.rw);
    id_uses_rs = id.urs; id_uses_rt = id.urt;
    id_reg_wr = id.wr; id_load = id.load; id_branch = id.br;
    ex_taken = tk;
  endtask

  // Called just after a falling edge; checks one cycle and advances the model.
  task automatic step(input ins_t id, input bit tk);
    bit e_taken, e_stall;
    drive(id, tk);
    @(posedge clk); #1;
    e_taken = tk && ex_m.valid && ex_m.br;
    e_stall = !e_taken && ex_m.valid && ex_m.load &&
              ((id.urs && writer(ex_m, id.rs)) || (id.urt && writer(ex_m, id.rt)));
    obs_fa = int'(fwd_a); obs_fb = int'(fwd_b); obs_hold = int'(pc_hold);
    obs_flush = int'(ifid_flush); obs_bub = int'(idex_bubble);
    chk("fwd_a", fwd_a, fsel(ex_m.urs, ex_m.rs));
    chk("fwd_b", fwd_b, fsel(ex_m.urt, ex_m.rt));
    chk("pc_hold", pc_hold, e_stall);
    chk("ifid_hold", ifid_hold, e_stall);
    chk("ifid_flush", ifid_flush, e_taken);
    chk("idex_bubble", idex_bubble, e_stall || e_taken);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
    last_stall = e_stall;
    @(negedge clk);
    if (e_stall && m_sc < MAXC) m_sc++;
    if (e_taken && m_fc < MAXC) m_fc++;
    wb_m = mem_m; mem_m = ex_m;
    ex_m = (e_stall || e_taken) ? empty : id;
    #1;
  endtask

  task automatic do_reset();
    drive(empty, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_pc_hold", pc_hold, 0);
    chk("rst_flush", ifid_flush, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  ins_t nop, add31, sub43, lw3, add4u3, w0, r0, lw0, use0, beq, bne;
  ins_t cur;

  initial begin
    empty = '{default: 0};
    model_clear();
    nop    = mk(0, 0, 0, 0, 0, 0, 0, 0);
    add31  = mk(1, 0, 0, 3, 1, 2, 1, 1);
    sub43  = mk(1, 0, 0, 4, 3, 5, 1, 1);
    lw3    = mk(1, 1, 0, 3, 1, 0, 1, 0);
    add4u3 = mk(1, 0, 0, 4, 2, 3, 1, 1);
    w0     = mk(1, 0, 0, 0, 1, 2, 1, 1);
    r0     = mk(1, 0, 0, 4, 0, 0, 1, 1);
    lw0    = mk(1, 1, 0, 0, 1, 0, 1, 0);
    use0   = mk(1, 0, 0, 5, 0, 0, 1, 1);
    beq    = mk(0, 0, 1, 0, 1, 2, 1, 1);
    bne    = mk(0, 0, 1, 0, 3, 4, 1, 1);

    #1 reset = 1'b1;
    #20;
    do_reset();

    // back-to-back ALU dependency forwards from MEM, one nop apart from WB
    step(add31, 0); step(sub43, 0); step(nop, 0);
    chk("dir_fwd_mem", obs_fa, 1);
    chk("dir_fwd_mem_nostall", obs_hold, 0);
    do_reset();
    step(add31, 0); step(nop, 0); step(sub43, 0); step(nop, 0);
    chk("dir_fwd_wb", obs_fa, 2);

    // load-use: one bubble, then WB forward
    do_reset();
    step(lw3, 0); step(add4u3, 0);
    chk("dir_lu_hold", obs_hold, 1);
    chk("dir_lu_bubble", obs_bub, 1);
    step(add4u3, 0);
    chk("dir_lu_once", obs_hold, 0);
    step(nop, 0);
    chk("dir_lu_fwd_b", obs_fb, 2);
    step(nop, 0);
    chk("dir_lu_cnt", stall_cnt, 1);

    // register 0 is never a hazard
    do_reset();
    step(w0, 0); step(r0, 0); step(nop, 0);
    chk("dir_r0_fa", obs_fa, 0);
    chk("dir_r0_fb", obs_fb, 0);
    step(lw0, 0); step(use0, 0);
    chk("dir_r0_nostall", obs_hold, 0);

    // taken branch with lw->use right behind it
    do_reset();
    step(beq, 0); step(lw3, 1);
    chk("dir_br_flush", obs_flush, 1);
    chk("dir_br_bubble", obs_bub, 1);
    chk("dir_br_nohold", obs_hold, 0);
    step(add4u3, 0);
    chk("dir_br_nostall", obs_hold, 0);
    step(nop, 0);
    chk("dir_br_fcnt", flush_cnt, 1);
    chk("dir_br_scnt", stall_cnt, 0);

    // not-taken branch and stray ex_taken are ignored
    do_reset();
    step(bne, 0); step(nop, 0);
    chk("dir_nt_flush", obs_flush, 0);
    step(add31, 0); step(nop, 1);
    chk("dir_nb_flush", obs_flush, 0);

    // reset while a stall is being asserted
    do_reset();
    step(lw3, 0);
    drive(add4u3, 1'b0);
    @(posedge clk); #1;
    chk("dir_rst_pre_hold", pc_hold, 1);
    do_reset();
    chk("dir_rst_hold", pc_hold, 0);
    chk("dir_rst_bubble", idex_bubble, 0);
    chk("dir_rst_fcnt", flush_cnt, 0);
    step(lw3, 0); step(add4u3, 0);
    chk("dir_rst_restall", obs_hold, 1);
    step(add4u3, 0); step(nop, 0);
    chk("dir_rst_cnt", stall_cnt, 1);

    // random stream; long enough to saturate both counters
    do_reset();
    cur = rnd();
    for (int n = 0; n < 400; n++) begin
      step(cur, 1'($urandom_range(0, 1)));
      if (!last_stall) cur = rnd();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
